// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cnn_pkg
// Description : Shared definitions for the CNN pooling stage: default plane
//               geometry, pooled-plane dimensions, counter width helper and
//               the binary32 max function (sign/magnitude compare, no FPU).
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  localparam int FP_WIDTH         = 32;
  localparam int DEF_IMAGE_WIDTH  = 16;
  localparam int DEF_IMAGE_HEIGHT = 16;
  localparam int POOL_W           = DEF_IMAGE_WIDTH / 2;
  localparam int POOL_H           = DEF_IMAGE_HEIGHT / 2;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bitwise binary32 max. Differing signs: the non-negative operand wins, so
  // fmax(+0,-0) = +0. Equal signs: compare magnitudes, reversed for negatives.
  // Ties return a. NaNs are ordered purely by their bit patterns.
  function automatic logic [FP_WIDTH-1:0] fp32_max(input logic [FP_WIDTH-1:0] a,
                                                   input logic [FP_WIDTH-1:0] b);
    logic [FP_WIDTH-1:0] res;
    res = a;
    if (a[31] != b[31]) begin
      res = a[31] ? b : a;
    end else if (!a[31]) begin
      res = (b[30:0] > a[30:0]) ? b : a;
    end else begin
      res = (b[30:0] < a[30:0]) ? b : a;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_fp32_max.sv
`default_nettype none
// ============================================================================
// Module      : cnn_fp32_max
// Description : Combinational two-input binary32 maximum.
// Ports       : i_a, i_b  - operands (binary32)
//               o_max     - larger operand; i_a on a tie
// Revision    : 1.0 - initial release
// ============================================================================
import cnn_pkg::*;

module cnn_fp32_max (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_max
);

  assign o_max = fp32_max(i_a, i_b);

endmodule
`default_nettype wire

// File: rtl/cnn_maxpool_2x2_multi_channel.sv
`default_nettype none
// ============================================================================
// Module      : cnn_maxpool_2x2_multi_channel
// Description : 2x2 / stride-2 max pooling over a channel-sequential binary32
//               pixel stream (channel-major, row-major within each plane).
// Ports       : clk        - clock, rising edge
//               reset      - synchronous, active-low reset
//               valid_in   - pxl_in valid this cycle (no back-pressure)
//               pxl_in     - input pixel
//               pxl_out    - pooled pixel, registered, holds between outputs
//               valid_out  - one-cycle pulse per pooled pixel
//               done_out   - pulses with the last pooled pixel of a frame
// Revision    : 1.0 - initial release
// ============================================================================
import cnn_pkg::*;

module cnn_maxpool_2x2_multi_channel #(
  parameter int DATA_WIDTH   = 32,
  parameter int IMAGE_WIDTH  = 16,
  parameter int IMAGE_HEIGHT = 16,
  parameter int CHANNEL_NUM  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  done_out
);

  localparam int c_pool_w = IMAGE_WIDTH / 2;
  localparam int c_col_w  = cnt_w(IMAGE_WIDTH);
  localparam int c_row_w  = cnt_w(IMAGE_HEIGHT);
  localparam int c_ch_w   = cnt_w(CHANNEL_NUM);
  localparam int c_slot_w = cnt_w(c_pool_w);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("cnn_maxpool_2x2_multi_channel: DATA_WIDTH must be 32");
  end

  logic [c_col_w-1:0]    r_col;
  logic [c_row_w-1:0]    r_row;
  logic [c_ch_w-1:0]     r_ch;
  logic [31:0]           r_h_max;
  logic [31:0]           r_linebuf [c_pool_w];
  logic [31:0]           r_pxl_out;
  logic                  r_valid_out;
  logic                  r_done_out;

  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_ch_last;
  logic [c_slot_w-1:0]   w_slot;
  logic [31:0]           w_h_max;
  logic [31:0]           w_v_max;
  logic                  w_emit;
  logic                  w_lb_wr;

  assign w_col_last = (r_col == c_col_w'(IMAGE_WIDTH - 1));
  assign w_row_last = (r_row == c_row_w'(IMAGE_HEIGHT - 1));
  assign w_ch_last  = (r_ch  == c_ch_w'(CHANNEL_NUM - 1));
  assign w_slot     = c_slot_w'(r_col >> 1);

  // Window closes on an odd row / odd column pixel; the top half of the
  // window is parked in the line buffer on the preceding even row.
  assign w_emit  = valid_in && r_row[0] && r_col[0];
  assign w_lb_wr = valid_in && !r_row[0] && r_col[0];

  cnn_fp32_max u_h_max (
    .i_a   (r_h_max),
    .i_b   (pxl_in),
    .o_max (w_h_max)
  );

  cnn_fp32_max u_v_max (
    .i_a   (r_linebuf[w_slot]),
    .i_b   (w_h_max),
    .o_max (w_v_max)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
      r_ch  <= '0;
    end else if (valid_in) begin
      if (w_col_last) begin
        r_col <= '0;
        if (w_row_last) begin
          r_row <= '0;
          r_ch  <= w_ch_last ? '0 : r_ch + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_h_max     <= '0;
      r_pxl_out   <= '0;
      r_valid_out <= 1'b0;
      r_done_out  <= 1'b0;
    end else begin
      if (valid_in && !r_col[0]) begin
        r_h_max <= pxl_in;
      end
      if (w_emit) begin
        r_pxl_out <= w_v_max;
      end
      r_valid_out <= w_emit;
      r_done_out  <= w_emit && w_col_last && w_row_last && w_ch_last;
    end
  end

  // Line buffer needs no reset: every slot is written on an even row before
  // the odd row that reads it.
  always_ff @(posedge clk) begin
    if (reset && w_lb_wr) begin
      r_linebuf[w_slot] <= w_h_max;
    end
  end

  assign pxl_out   = r_pxl_out;
  assign valid_out = r_valid_out;
  assign done_out  = r_done_out;

endmodule
`default_nettype wire
